// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial adder slice: nibble width, FSM state type
// and the WIDTH legality check.
package serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit width_ok(input int unsigned w);
    return ((w % NIBBLE_W) == 0) && (w >= 8);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Producer/consumer handshake bundle for serial_adder_ctrl.
// The sub line exists only when SUBTRACT_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  // master: the surrounding producer/consumer; slave: the adder block
  modport master (
`ifdef SUBTRACT_EN
    output sub,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/serial_adder_ctrl_nibble_adder.sv
// Shared 4-bit datapath: a + b + cin with carry-out.
module nibble_adder
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  end
endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide adder built from one nibble adder, one nibble per clock, LSB first.
// Optional macro SUBTRACT_EN adds a sub input computing a + ~b + 1.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH:0]       sum_q;
  logic                 carry_q;
  logic [IDX_W-1:0]     idx;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout;

  // Operand nibble select driven by the pass index
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_adder u_nibble_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a;
`ifdef SUBTRACT_EN
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
`else
            b_q     <= bus.b;
            carry_q <= 1'b0;
`endif
            idx        <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum_q[i*NIBBLE_W +: NIBBLE_W] <= nib_sum;
            end
          end
          carry_q <= nib_cout;
          if (idx == LAST_IDX) begin
            // Index parks at zero so non-power-of-two NIBBLES never overruns
            sum_q[WIDTH] <= nib_cout;
            idx          <= '0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=16.
// Subtraction scenarios run only when SUBTRACT_EN is defined.
module tb_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic [15:0] a_v, input logic [15:0] b_v, input logic sub_v);
    @(negedge clk);
    bus.a = a_v;
    bus.b = b_v;
`ifdef SUBTRACT_EN
    bus.sub = sub_v;
`else
    if (sub_v) bus.a = a_v;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.sum !== 17'h00000) begin
      n_fail++;
      $display("FAIL reset_sum: got %h want 00000", bus.sum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    drive_op(16'h1234, 16'h4321, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (c < 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_run_c%0d: out_valid=%b in_ready=%b busy=%b, want 0 0 1",
                   c, bus.out_valid, bus.in_ready, bus.busy);
        end
      end else begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 17'h05555) begin
          n_fail++;
          $display("FAIL basic_done: out_valid=%b sum=%h, want 1 05555", bus.out_valid, bus.sum);
        end
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_carry_ripple;
    int cyc;
    drive_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h10000) begin
      n_fail++;
      $display("FAIL carry_ripple: cycles=%0d sum=%h, want 4 10000", cyc, bus.sum);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    bus.out_ready = 1'b0;
    drive_op(16'h00FF, 16'h0001, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h00100) begin
      n_fail++;
      $display("FAIL bp_first: cycles=%0d sum=%h, want 4 00100", cyc, bus.sum);
    end
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 17'h00100) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: out_valid=%b in_ready=%b sum=%h, want 1 0 00100",
                 c, bus.out_valid, bus.in_ready, bus.sum);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    drive_op(16'h1234, 16'hFFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum !== 17'h00000) begin
      n_fail++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b sum=%h, want 1 0 0 00000",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(16'h000A, 16'h0005, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h0000F) begin
      n_fail++;
      $display("FAIL after_reset_op: cycles=%0d sum=%h, want 4 0000F", cyc, bus.sum);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    bus.out_ready = 1'b0;
    drive_op(16'h0003, 16'h0004, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h00007) begin
      n_fail++;
      $display("FAIL b2b_first: cycles=%0d sum=%h, want 4 00007", cyc, bus.sum);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = 16'h8000;
    bus.b = 16'h8000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handshake: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: in_ready=%b busy=%b, want 0 1", bus.in_ready, bus.busy);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h10000) begin
      n_fail++;
      $display("FAIL b2b_second: cycles=%0d sum=%h, want 4 10000", cyc, bus.sum);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract;
    int cyc;
    drive_op(16'h0007, 16'h0005, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h10002) begin
      n_fail++;
      $display("FAIL sub_no_borrow: cycles=%0d sum=%h, want 4 10002", cyc, bus.sum);
    end
    @(posedge clk);
    #1;
    drive_op(16'h0005, 16'h0007, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || bus.sum !== 17'h0FFFE) begin
      n_fail++;
      $display("FAIL sub_borrow: cycles=%0d sum=%h, want 4 0FFFE", cyc, bus.sum);
    end
    @(posedge clk);
    #1;
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
`ifdef SUBTRACT_EN
    bus.sub       = 1'b0;
`endif
    test_reset;
    test_basic;
    test_carry_ripple;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
`ifdef SUBTRACT_EN
    test_subtract;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
